layer_feeder: RTL and testbench

LAYER_FEEDER -- requirements
Module: layer_feeder

---
 rtl/layer_feeder.sv | 163 ++++++++++++++++
 tb/tb_layer_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_feeder.sv
// Input feeder for one neural-network layer: buffers incoming scalers, sequences
// weight-row reads and broadcasts each scaler with an accumulate strobe.
module layer_feeder #(
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BITS  = 2,
    parameter int NUM_INPUTS  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int WADDR_WIDTH = 3,
    parameter int ACC_LATENCY = 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  IN_DATA,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic                             START,
    output logic [WADDR_WIDTH-1:0]           WEIGHT_ADDR,
    output logic                             WEIGHT_RD_EN,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]  SCALER_OUT,
    output logic                             ACC_EN,
    output logic                             ACC_CLR,
    output logic                             BUSY,
    output logic                             DONE
);

    localparam int W  = BIT_WIDTH + EXTRA_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(ACC_LATENCY + 2);

    localparam logic [WADDR_WIDTH-1:0] LAST_IDX = WADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [LW-1:0]          LAT_CNT  = LW'(ACC_LATENCY);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic [W-1:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   full;
    logic                   empty;
    logic                   push;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [WADDR_WIDTH-1:0] index;
    logic [WADDR_WIDTH-1:0] index_nxt;
    logic [LW-1:0]          wait_cnt;
    logic [LW-1:0]          wait_nxt;

    logic                   vld_p0;
    logic [W-1:0]           data_p0;
    logic                   vld_p1;
    logic [W-1:0]           scaler_p1;

    // The extra pointer bit separates a wrapped (full) FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready comes from registered pointers only, so a same-cycle pop never frees a full slot.
    assign IN_READY = RESET && !full;
    assign push     = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (vld_p0) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        wait_nxt  = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                index_nxt = '0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (vld_p0) begin
                    index_nxt = index + 1'b1;
                    if (index == LAST_IDX) begin
                        state_nxt = ST_WAIT;
                        wait_nxt  = LAT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_FIN;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            index    <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            index    <= index_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Stage p0: pop and weight read issued together in RUN.
    assign vld_p0  = (state == ST_RUN) && !empty;
    assign data_p0 = mem[rd_ptr[AW-1:0]];

    // Stage p1: scaler lands alongside the weight memory read data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_p1    <= 1'b0;
            scaler_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                scaler_p1 <= data_p0;
            end
        end
    end

    assign WEIGHT_RD_EN = vld_p0;
    assign WEIGHT_ADDR  = index;
    assign SCALER_OUT   = scaler_p1;
    assign ACC_EN       = vld_p1;
    assign ACC_CLR      = (state == ST_CLEAR);
    assign BUSY         = (state != ST_IDLE);
    assign DONE         = (state == ST_FIN);

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder: basic pass, starvation, back-pressure,
// back-to-back passes, ignored START and reset in the middle of a pass.
module tb_layer_feeder;

    localparam int W   = 34;
    localparam int NIN = 8;

    logic         CLK;
    logic         RESET;
    logic [W-1:0] IN_DATA;
    logic         IN_VALID;
    logic         IN_READY;
    logic         START;
    logic [2:0]   WEIGHT_ADDR;
    logic         WEIGHT_RD_EN;
    logic [W-1:0] SCALER_OUT;
    logic         ACC_EN;
    logic         ACC_CLR;
    logic         BUSY;
    logic         DONE;

    layer_feeder dut (
        .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .START(START), .WEIGHT_ADDR(WEIGHT_ADDR),
        .WEIGHT_RD_EN(WEIGHT_RD_EN), .SCALER_OUT(SCALER_OUT), .ACC_EN(ACC_EN),
        .ACC_CLR(ACC_CLR), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int cyc = 0;
    int acc_cnt = 0, done_cnt = 0, clr_cnt = 0;
    int pass_rd = 0, pass_acc = 0, first_rd = -1, last_rd = -1;
    int last_acc_cyc = -1, done_cyc = -1, clr_cyc = -1, exp_addr = 0;
    logic [W-1:0] first_scaler;
    logic prev_rd = 1'b0;
    logic [W-1:0] exp_q[$];

    int feed_next = 1, feed_last = 0, feed_gap = 1, gap_cnt = 0;

    function automatic logic [W-1:0] fp(input int k);
        logic [31:0] t;
        case ((k - 1) % 16)
            0:  t = 32'h3F800000;  1:  t = 32'h40000000;
            2:  t = 32'h40400000;  3:  t = 32'h40800000;
            4:  t = 32'h40A00000;  5:  t = 32'h40C00000;
            6:  t = 32'h40E00000;  7:  t = 32'h41000000;
            8:  t = 32'h41100000;  9:  t = 32'h41200000;
            10: t = 32'h41300000;  11: t = 32'h41400000;
            12: t = 32'h41500000;  13: t = 32'h41600000;
            14: t = 32'h41700000;  default: t = 32'h41800000;
        endcase
        return {2'b01, t};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_feed(input int first, input int last, input int gap);
        feed_next = first;
        feed_last = last;
        feed_gap  = gap;
        gap_cnt   = 0;
        IN_VALID  = (first <= last);
        IN_DATA   = fp(first);
    endtask

    // One clock: record pushes, observe outputs at #1 after the edge, then drive the feed.
    task automatic tick();
        logic pushed;
        logic [W-1:0] want;
        pushed = IN_VALID && IN_READY;
        @(posedge CLK);
        #1;
        cyc++;
        if (pushed) begin
            exp_q.push_back(IN_DATA);
            feed_next++;
        end
        check("acc_en_follows_read", ACC_EN, prev_rd);
        if (ACC_CLR) begin
            clr_cnt++;
            clr_cyc  = cyc;
            pass_rd  = 0;
            pass_acc = 0;
            first_rd = -1;
            exp_addr = 0;
        end
        if (ACC_EN) begin
            acc_cnt++;
            if (pass_acc == 0) first_scaler = SCALER_OUT;
            pass_acc++;
            last_acc_cyc = cyc;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("scaler_order", SCALER_OUT, want);
        end
        if (WEIGHT_RD_EN) begin
            check("weight_addr", WEIGHT_ADDR, exp_addr);
            exp_addr = (exp_addr + 1) % NIN;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            pass_rd++;
        end
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_rd = WEIGHT_RD_EN;
        if (pushed) gap_cnt = feed_gap - 1;
        else if (gap_cnt > 0) gap_cnt--;
        if (feed_next <= feed_last && gap_cnt == 0) begin
            IN_VALID = 1'b1;
            IN_DATA  = fp(feed_next);
        end else begin
            IN_VALID = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, IN_READY, 1'b0);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_done"}, DONE, 1'b0);
        check({tag, "_acc_en"}, ACC_EN, 1'b0);
        check({tag, "_acc_clr"}, ACC_CLR, 1'b0);
        check({tag, "_rd_en"}, WEIGHT_RD_EN, 1'b0);
        check({tag, "_addr"}, WEIGHT_ADDR, 3'd0);
        check({tag, "_scaler"}, SCALER_OUT, '0);
    endtask

    task automatic wait_full();
        for (int i = 0; i < 20 && IN_READY; i++) tick();
        check("fifo_filled", IN_READY, 1'b0);
    endtask

    initial begin
        int d0, c0, a0;
        logic s1, s2;
        RESET = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;

        // Reset state
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        tick();
        check("ready_after_release", IN_READY, 1'b1);
        check("idle_busy", BUSY, 1'b0);

        // Back-pressure in IDLE: four pushes then IN_READY drops
        set_feed(1, 8, 1);
        repeat (3) tick();
        check("ready_after_3_pushes", IN_READY, 1'b1);
        tick();
        check("ready_after_4_pushes", IN_READY, 1'b0);
        repeat (3) tick();
        check("no_push_while_full", feed_next, 5);
        check("idle_no_pop", exp_q.size(), 4);

        // Basic pass
        d0 = done_cnt;
        START = 1'b1; tick(); START = 1'b0;
        check("clear_pulse", ACC_CLR, 1'b1);
        check("clear_busy", BUSY, 1'b1);
        tick();
        check("clear_one_cycle", ACC_CLR, 1'b0);
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        check("basic_done", done_cnt - d0, 1);
        check("basic_acc_count", pass_acc, 8);
        check("basic_first_read", first_rd - clr_cyc, 1);
        check("basic_reads_back_to_back", last_rd - first_rd, 7);
        check("basic_done_latency", done_cyc - last_acc_cyc, 2);
        check("basic_scoreboard_empty", exp_q.size(), 0);
        tick();
        check("basic_done_one_cycle", DONE, 1'b0);
        check("basic_idle", BUSY, 1'b0);

        // Starvation: START on empty FIFO, one word every 3 cycles
        d0 = done_cnt;
        START = 1'b1; tick(); START = 1'b0;
        set_feed(9, 16, 3);
        for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
        check("starve_done", done_cnt - d0, 1);
        check("starve_acc_count", pass_acc, 8);
        check("starve_read_count", pass_rd, 8);
        check("starve_read_spacing", last_rd - first_rd, 21);
        repeat (3) tick();
        check("starve_single_done", done_cnt - d0, 1);

        // Back-to-back passes with 12 words queued
        set_feed(1, 12, 1);
        wait_full();
        d0 = done_cnt; c0 = clr_cnt;
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        check("b2b_pass1_acc", pass_acc, 8);
        check("b2b_pass1_first", first_scaler, fp(1));
        repeat (2) tick();
        check("b2b_leftover_kept", exp_q.size(), 4);
        check("b2b_leftover_full", IN_READY, 1'b0);

        // Second pass, with START pulsed during RUN and during WAIT
        feed_last = 16;
        IN_VALID  = 1'b1;
        d0 = done_cnt;
        s1 = 1'b0; s2 = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            START = 1'b0;
            if (pass_rd == 3 && !s1) begin START = 1'b1; s1 = 1'b1; end
            else if (pass_acc == 8 && !s2) begin START = 1'b1; s2 = 1'b1; end
            tick();
        end
        START = 1'b0;
        check("b2b_pass2_acc", pass_acc, 8);
        check("b2b_pass2_first", first_scaler, fp(9));
        repeat (5) tick();
        check("ignored_start_clr", clr_cnt - c0, 2);
        check("ignored_start_done", done_cnt - d0, 1);
        check("ignored_start_idle", BUSY, 1'b0);

        // Reset after 3 pops of a pass
        set_feed(1, 8, 1);
        wait_full();
        d0 = done_cnt;
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 20 && pass_acc < 3; i++) tick();
        check("midrun_acc_before_reset", pass_acc, 3);
        RESET = 1'b0;
        IN_VALID = 1'b0;
        feed_last = 0;
        #1;
        check_reset_outputs("midrun");
        exp_q.delete();
        prev_rd = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        a0 = acc_cnt;
        tick();
        check("midrun_ready_after_release", IN_READY, 1'b1);
        repeat (4) tick();
        check("midrun_no_done", done_cnt - d0, 0);
        check("midrun_no_acc", acc_cnt - a0, 0);
        START = 1'b1; tick(); START = 1'b0;
        repeat (5) tick();
        check("midrun_fifo_discarded", pass_rd, 0);
        set_feed(1, 8, 1);
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        check("midrun_new_pass_done", done_cnt - d0, 1);
        check("midrun_new_pass_acc", pass_acc, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
